// File: rtl/store_rmw_controller_pkg.sv
// rtl/store_rmw_controller_pkg.sv - shared store type codes, FSM encoding and alignment helper
package store_rmw_controller_pkg;

    localparam int WORD_OFFSET_BITS = 2;

    localparam logic [1:0] STORE_SB = 2'd0;
    localparam logic [1:0] STORE_SH = 2'd1;
    localparam logic [1:0] STORE_SW = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MRG  = 3'd2,
        ST_WR   = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Type code 3 is handled exactly like SW.
    function automatic logic is_misaligned(input logic [1:0]                  store_type,
                                           input logic [WORD_OFFSET_BITS-1:0] offset);
        case (store_type)
            STORE_SB: return 1'b0;
            STORE_SH: return offset[0];
            default:  return offset != '0;
        endcase
    endfunction

endpackage

// File: rtl/store_rmw_controller_if.sv
// rtl/store_rmw_controller_if.sv - store request and single-port data memory bundle
interface store_rmw_controller_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_type;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_data;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic [31:0]           mem_rdata;
    logic                  mem_we;
    logic [31:0]           mem_wdata;

    // Pipeline and memory side.
    modport master (
        output req_valid, req_type, req_addr, req_data, mem_rdata,
        input  req_ready, busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
    );

    // Controller side.
    modport slave (
        input  req_valid, req_type, req_addr, req_data, mem_rdata,
        output req_ready, busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - little-endian byte/halfword lane merge into an old word
module store_lane_merge
    import store_rmw_controller_pkg::*;
(
    input  logic [31:0]                 new_data,
    input  logic [31:0]                 old_word,
    input  logic [1:0]                  store_type,
    input  logic [WORD_OFFSET_BITS-1:0] offset,
    output logic [31:0]                 merged
);

    always_comb begin
        merged = old_word;
        case (store_type)
            STORE_SB: begin
                case (offset)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    default: merged[31:24] = new_data[7:0];
                endcase
            end
            STORE_SH: begin
                // Odd halfword offsets never reach here; they are rejected as misaligned.
                if (offset[1]) merged[31:16] = new_data[15:0];
                else           merged[15:0]  = new_data[15:0];
            end
            default: merged = new_data;
        endcase
    end

endmodule

// File: rtl/store_rmw_controller.sv
// rtl/store_rmw_controller.sv - MEM-stage store sequencer: direct SW, read-modify-write SB/SH
module store_rmw_controller
    import store_rmw_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    store_rmw_controller_if.slave bus
);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            type_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merged;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic                  accept;

    assign accept       = bus.req_valid && (state_q == ST_IDLE);
    assign aligned_addr = {addr_q[ADDR_WIDTH-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};

    store_lane_merge u_lane_merge (
        .new_data   (wdata_q),
        .old_word   (bus.mem_rdata),
        .store_type (type_q),
        .offset     (addr_q[WORD_OFFSET_BITS-1:0]),
        .merged     (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // wdata_q holds the raw store data until MRG replaces it with the merged word,
    // so SW writes it unchanged and SB/SH merge from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            type_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= bus.req_addr;
            type_q  <= bus.req_type;
            wdata_q <= bus.req_data;
        end else if (state_q == ST_MRG) begin
            wdata_q <= merged;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_misaligned(bus.req_type, bus.req_addr[WORD_OFFSET_BITS-1:0]))
                        state_d = ST_ERR;
                    else if (bus.req_type == STORE_SB || bus.req_type == STORE_SH)
                        state_d = ST_RD;
                    else
                        state_d = ST_WR;
                end
            end
            ST_RD:   state_d = ST_MRG;
            ST_MRG:  state_d = ST_WR;
            ST_WR:   state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.req_ready = (state_q == ST_IDLE);
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            ST_RD: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = aligned_addr;
            end
            ST_WR: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = aligned_addr;
                bus.mem_wdata = wdata_q;
                bus.done      = 1'b1;
            end
            ST_ERR:  bus.err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_rmw_controller.sv
// tb/tb_store_rmw_controller.sv - self-checking bench for store_rmw_controller
module tb_store_rmw_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wr_count;
    logic mon_en;

    logic [31:0] tb_mem    [16];
    logic [31:0] model_mem [16];

    logic [31:0] lm_new;
    logic [31:0] lm_old;
    logic [1:0]  lm_type;
    logic [1:0]  lm_off;
    logic [31:0] lm_merged;

    store_rmw_controller_if #(.ADDR_WIDTH(32)) bus ();

    store_rmw_controller #(.ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    store_lane_merge u_merge (
        .new_data   (lm_new),
        .old_word   (lm_old),
        .store_type (lm_type),
        .offset     (lm_off),
        .merged     (lm_merged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: read data one cycle after mem_re, writes land at the edge.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= tb_mem[bus.mem_addr[5:2]];
        if (bus.mem_we) begin
            tb_mem[bus.mem_addr[5:2]] = bus.mem_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {bus.req_ready, bus.busy, bus.done, bus.err, bus.mem_re, bus.mem_we};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("one_access", {31'd0, bus.mem_re & bus.mem_we}, 32'd0);
            if (!bus.mem_re && !bus.mem_we) check("addr_zero_idle", bus.mem_addr, 32'd0);
        end
    end

    function automatic logic model_misaligned(input logic [1:0] t, input logic [1:0] off);
        if (t == 2'd0) return 1'b0;
        if (t == 2'd1) return off[0];
        return off != 2'd0;
    endfunction

    function automatic logic [31:0] model_merge(input logic [1:0] t, input logic [1:0] off,
                                                input logic [31:0] nd, input logic [31:0] old);
        logic [7:0]  b [4];
        int          n;
        int          base;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        n    = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
        base = (t == 2'd0) ? int'(off) : (t == 2'd1) ? int'(off) / 2 * 2 : 0;
        for (int k = 0; k < n; k++) b[base + k] = nd[8*k +: 8];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        tb_mem[a[5:2]]    = v;
        model_mem[a[5:2]] = v;
    endtask

    task automatic run_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] al;
        logic [31:0] exp_word;
        int          wr_before;
        al = {a[31:2], 2'b00};
        @(negedge clk);
        check("ready_before", {26'd0, flags()}, 32'b100000);
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_data  = d;
        wr_before     = wr_count;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (model_misaligned(t, a[1:0])) begin
            check("err_c1_flags", {26'd0, flags()}, 32'b010100);
            @(negedge clk);
            check("err_no_write", wr_count, wr_before);
        end else if (t[1]) begin
            check("sw_c1_flags", {26'd0, flags()}, 32'b011001);
            check("sw_c1_addr", bus.mem_addr, al);
            check("sw_c1_wdata", bus.mem_wdata, d);
            model_mem[a[5:2]] = d;
            @(negedge clk);
        end else begin
            check("rmw_c1_flags", {26'd0, flags()}, 32'b010010);
            check("rmw_c1_addr", bus.mem_addr, al);
            @(negedge clk);
            check("rmw_c2_flags", {26'd0, flags()}, 32'b010000);
            @(negedge clk);
            exp_word = model_merge(t, a[1:0], d, model_mem[a[5:2]]);
            check("rmw_c3_flags", {26'd0, flags()}, 32'b011001);
            check("rmw_c3_addr", bus.mem_addr, al);
            check("rmw_c3_wdata", bus.mem_wdata, exp_word);
            model_mem[a[5:2]] = exp_word;
            @(negedge clk);
        end
        check("idle_after", {26'd0, flags()}, 32'b100000);
        check("mem_word", tb_mem[a[5:2]], model_mem[a[5:2]]);
    endtask

    initial begin
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        int          wr_before;

        checks        = 0;
        errors        = 0;
        wr_count      = 0;
        mon_en        = 1'b0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_type  = 2'd0;
        bus.req_addr  = 32'd0;
        bus.req_data  = 32'd0;
        bus.mem_rdata = 32'd0;
        for (int i = 0; i < 16; i++) set_word(32'(i * 4), $urandom);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {26'd0, flags()}, 32'b100000);
        check("reset_addr", bus.mem_addr, 32'd0);
        check("reset_wdata", bus.mem_wdata, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Stand-alone lane merge.
        lm_new = 32'h000000CD; lm_old = 32'h11223344; lm_type = 2'd0; lm_off = 2'd1;
        #1 check("merge_sb_off1", lm_merged, 32'h1122CD44);
        for (int i = 0; i < 16; i++) begin
            lm_new  = $urandom;
            lm_old  = $urandom;
            lm_type = 2'($urandom_range(0, 3));
            lm_off  = (lm_type == 2'd0) ? 2'($urandom_range(0, 3)) :
                      (lm_type == 2'd1) ? 2'($urandom_range(0, 1) * 2) : 2'd0;
            #1 check("merge_rand", lm_merged, model_merge(lm_type, lm_off, lm_new, lm_old));
        end

        // Directed scenarios.
        set_word(32'h1000, 32'h11223344);
        run_store(2'd0, 32'h1003, 32'h000000AB);
        check("sb_0x1003_word", tb_mem[0], 32'hAB223344);
        set_word(32'h2000, 32'h11223344);
        run_store(2'd1, 32'h2002, 32'h0000BEEF);
        check("sh_0x2002_word", tb_mem[0], 32'hBEEF3344);
        set_word(32'h1000, 32'h11223344);
        run_store(2'd0, 32'h1001, 32'h000000CD);
        check("sb_off1_word", tb_mem[0], 32'h1122CD44);
        run_store(2'd2, 32'h3000, 32'hDEADBEEF);
        check("sw_0x3000_word", tb_mem[0], 32'hDEADBEEF);
        run_store(2'd1, 32'h0001, 32'h12345678);
        run_store(2'd2, 32'h0002, 32'h12345678);
        run_store(2'd3, 32'h0010, 32'hCAFEF00D);

        // SB with req_valid held high, SW queued behind it.
        set_word(32'h0004, 32'h55667788);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_type  = 2'd0;
        bus.req_addr  = 32'h0006;
        bus.req_data  = 32'h00000099;
        @(negedge clk);
        bus.req_type  = 2'd2;
        bus.req_addr  = 32'h0008;
        bus.req_data  = 32'hA5A55A5A;
        check("q_c1_flags", {26'd0, flags()}, 32'b010010);
        @(negedge clk);
        check("q_c2_flags", {26'd0, flags()}, 32'b010000);
        @(negedge clk);
        check("q_c3_flags", {26'd0, flags()}, 32'b011001);
        check("q_c3_wdata", bus.mem_wdata, 32'h55997788);
        @(negedge clk);
        check("q_c4_flags", {26'd0, flags()}, 32'b100000);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("q_c5_flags", {26'd0, flags()}, 32'b011001);
        check("q_c5_addr", bus.mem_addr, 32'h0008);
        check("q_c5_wdata", bus.mem_wdata, 32'hA5A55A5A);
        model_mem[1] = 32'h55997788;
        model_mem[2] = 32'hA5A55A5A;
        @(negedge clk);
        check("q_idle", {26'd0, flags()}, 32'b100000);
        check("q_word1", tb_mem[1], model_mem[1]);
        check("q_word2", tb_mem[2], model_mem[2]);

        // Reset while in MRG aborts the write.
        set_word(32'h000C, 32'h01020304);
        wr_before = wr_count;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_type  = 2'd0;
        bus.req_addr  = 32'h000E;
        bus.req_data  = 32'h000000FF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_flags", {26'd0, flags()}, 32'b100000);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_write", wr_count, wr_before);
        check("rst_word", tb_mem[3], 32'h01020304);
        run_store(2'd0, 32'h000E, 32'h000000FF);
        check("rst_after_word", tb_mem[3], 32'h01FF0304);

        // Randomized stores against the reference model.
        for (int i = 0; i < 40; i++) begin
            t = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (t == 2'd1) a[0] = 1'b0;
                if (t[1])      a[1:0] = 2'b00;
            end
            d = $urandom;
            run_store(t, a, d);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
